// File: rtl/spi_controller_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_controller_if -- host request/status and SPI pin bundle       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface spi_controller_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       sclk;
  logic       sdo;
  logic       miso;
  logic       cs;

  modport master (
    output start, rw, addr, wdata, miso,
    input  busy, done, rdata, sclk, sdo, cs
  );

  modport slave (
    input  start, rw, addr, wdata, miso,
    output busy, done, rdata, sclk, sdo, cs
  );
endinterface
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_controller -- 16-bit SPI frame master (rw, addr[6:0], data)   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module spi_controller #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input logic             clk,
  input logic             rst,
  spi_controller_if.slave bus
);

  localparam logic [7:0] C_DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] C_GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t      state;
  logic [7:0]  div_cnt;
  logic [7:0]  gap_cnt;
  logic [4:0]  bit_cnt;
  logic [15:0] frame;
  logic [15:0] capture;
  logic        cs;
  logic        sclk;
  logic        sdo;
  logic        busy;
  logic        done;
  logic [7:0]  rdata;
  logic [3:0]  next_bit;

  assign next_bit  = bit_cnt[3:0] + 4'd1;
  assign bus.cs    = cs;
  assign bus.sclk  = sclk;
  assign bus.sdo   = sdo;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.rdata = rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      gap_cnt <= '0;
      bit_cnt <= '0;
      frame   <= '0;
      capture <= '0;
      cs      <= 1'b1;
      sclk    <= 1'b0;
      sdo     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            frame   <= {bus.rw, bus.addr, bus.wdata};
            sdo     <= bus.rw;
            cs      <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= C_DIV_LAST;
            bit_cnt <= '0;
            capture <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            div_cnt <= C_DIV_LAST;
            sclk    <= 1'b1;
            sdo     <= frame[15];
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Each bit is a high half then a low half; sdo only moves on the rising half
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else if (sclk) begin
            sclk    <= 1'b0;
            capture <= {capture[14:0], bus.miso};
            div_cnt <= C_DIV_LAST;
          end else if (bit_cnt == 5'd15) begin
            rdata   <= capture[7:0];
            sdo     <= 1'b0;
            div_cnt <= C_DIV_LAST;
            state   <= HOLD;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
            sclk    <= 1'b1;
            sdo     <= frame[4'd15 - next_bit];
            div_cnt <= C_DIV_LAST;
          end
        end
        HOLD: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            cs      <= 1'b1;
            gap_cnt <= C_GAP_LAST;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_spi_controller -- random frames against a register peripheral  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_spi_controller;

  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 8;
  localparam int LAT        = 1 + CLK_DIV * 34 + GAP_CYCLES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_controller_if bus ();

  spi_controller #(
    .CLK_DIV   (CLK_DIV),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Peripheral: 16-bit frame {rw, addr, data}; samples sdo on sclk fall, answers the
  // addressed register on the data bits, commits writes when cs rises after 16 bits.
  logic [7:0]  periph_regs [128];
  logic [7:0]  shadow      [128];
  logic        prev_sclk   = 1'b0;
  logic        prev_cs     = 1'b1;
  logic        sdo_at_rise = 1'b0;
  int          pbit        = 0;
  int          frames_rx   = 0;
  int          done_cnt    = 0;
  logic [15:0] prx         = '0;
  logic [15:0] last_rx     = '0;
  logic [7:0]  resp        = '0;
  logic [7:0]  junk        = '0;

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.cs) begin
      if (!prev_cs && pbit == 16) begin
        last_rx = prx;
        frames_rx++;
        if (prx[15]) periph_regs[prx[14:8]] = prx[7:0];
      end
      pbit = 0;
      prx = '0;
      bus.miso = 1'b0;
    end else if (bus.sclk && !prev_sclk) begin
      sdo_at_rise = bus.sdo;
      if (pbit == 0) junk = 8'($urandom);
      if (pbit == 8) resp = periph_regs[prx[6:0]];
      if (pbit < 8) bus.miso = junk[7 - pbit];
      else if (pbit < 16) bus.miso = resp[15 - pbit];
    end else if (!bus.sclk && prev_sclk) begin
      chk("sdo_stable", bus.sdo, sdo_at_rise);
      prx = {prx[14:0], bus.sdo};
      pbit++;
    end
    prev_sclk = bus.sclk;
    prev_cs   = bus.cs;
  end

  task automatic do_frame(input logic w, input logic [6:0] a, input logic [7:0] d, input bit poke);
    int n;
    int csl;
    int dc0;
    logic [7:0] exp_rd;
    n = 1;
    csl = 0;
    exp_rd = shadow[a];
    @(negedge clk);
    bus.start = 1'b1; bus.rw = w; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.start = 1'b0;
    bus.rw = 1'($urandom); bus.addr = 7'($urandom); bus.wdata = 8'($urandom);
    dc0 = done_cnt;
    chk("setup_cs", bus.cs, 0);
    chk("setup_sclk", bus.sclk, 0);
    chk("setup_sdo", bus.sdo, w);
    chk("setup_busy", bus.busy, 1);
    while (!bus.done && n < LAT + 40) begin
      if (!bus.cs) csl++;
      bus.start = poke && (n == 60);
      if (poke && n == 60) begin
        bus.addr = ~a;
        bus.wdata = ~d;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk("latency", n, LAT);
    chk("cs_low_cycles", csl, 34 * CLK_DIV);
    chk("rdata", bus.rdata, exp_rd);
    chk("busy_at_done", bus.busy, 0);
    chk("tx_frame", last_rx, {w, a, d});
    if (w) shadow[a] = d;
    @(negedge clk);
    chk("done_width", bus.done, 0);
    chk("done_count", done_cnt - dc0, 1);
  endtask

  task automatic do_back_to_back();
    logic w1, w2;
    logic [6:0] a1, a2;
    logic [7:0] d1, d2, exp_rd;
    int n;
    int csh;
    w1 = 1'b1; a1 = 7'($urandom_range(1, 4)); d1 = 8'($urandom);
    w2 = 1'b0; a2 = a1;                       d2 = 8'($urandom);
    @(negedge clk);
    bus.start = 1'b1; bus.rw = w1; bus.addr = a1; bus.wdata = d1;
    @(negedge clk);
    bus.rw = w2; bus.addr = a2; bus.wdata = d2;
    n = 1;
    csh = 0;
    exp_rd = shadow[a1];
    while (!bus.done && n < LAT + 40) begin
      @(negedge clk);
      n++;
      if (bus.cs) csh++;
    end
    chk("b2b_latency1", n, LAT);
    // The done cycle is IDLE with cs high, so cs stays high through GAP plus that cycle.
    chk("b2b_cs_high", csh, GAP_CYCLES + 1);
    chk("b2b_rdata1", bus.rdata, exp_rd);
    chk("b2b_frame1", last_rx, {w1, a1, d1});
    shadow[a1] = d1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_next_cs", bus.cs, 0);
    chk("b2b_next_busy", bus.busy, 1);
    n = 1;
    while (!bus.done && n < LAT + 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_latency2", n, LAT);
    chk("b2b_rdata2", bus.rdata, d1);
    chk("b2b_frame2", last_rx, {w2, a2, d2});
    @(negedge clk);
  endtask

  task automatic do_reset_abort();
    int dc0;
    int fr0;
    @(negedge clk);
    bus.start = 1'b1; bus.rw = 1'b1; bus.addr = 7'd2; bus.wdata = 8'h5A;
    @(negedge clk);
    bus.start = 1'b0;
    dc0 = done_cnt;
    fr0 = frames_rx;
    repeat (15 * CLK_DIV + 1) @(negedge clk);
    chk("pre_abort_sclk", bus.sclk, 1);
    rst = 1'b1;
    #1;
    chk("abort_cs", bus.cs, 1);
    chk("abort_sclk", bus.sclk, 0);
    chk("abort_sdo", bus.sdo, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_rdata", bus.rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (LAT) @(negedge clk);
    chk("abort_no_done", done_cnt - dc0, 0);
    chk("abort_no_commit", frames_rx - fr0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      periph_regs[i] = 8'($urandom);
      shadow[i] = periph_regs[i];
    end
    bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs", bus.cs, 1);
    chk("rst_sclk", bus.sclk, 0);
    chk("rst_sdo", bus.sdo, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rdata", bus.rdata, 0);
    rst = 1'b0;

    do_frame(1'b1, 7'd3, 8'hA5, 1'b0);
    chk("write_frame_83a5", last_rx, 16'h83A5);

    for (int a = 1; a <= 4; a++) do_frame(1'b1, 7'(a), 8'($urandom), 1'b0);
    for (int a = 1; a <= 4; a++) do_frame(1'b0, 7'(a), 8'($urandom), 1'b0);
    for (int a = 1; a <= 4; a++) chk("periph_reg", periph_regs[a], shadow[a]);

    do_frame(1'b1, 7'd5, 8'h3C, 1'b0);
    do_frame(1'b0, 7'd5, 8'($urandom), 1'b0);
    chk("read_3c", bus.rdata, 8'h3C);

    do_frame(1'b0, 7'd3, 8'($urandom), 1'b1);
    do_back_to_back();
    do_reset_abort();
    do_frame(1'b0, 7'd2, 8'($urandom), 1'b0);

    for (int k = 0; k < 6; k++) do_frame(1'($urandom), 7'($urandom), 8'($urandom), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
